// File: rtl/pe_operand_mux.sv
`default_nettype none
// ============================================================================
// Module      : pe_operand_mux
// Description : Operand selector for a processing element. Picks one of
//               NUM_IN flattened input channels by sel and hands it to a
//               valid/ready downstream through a 2-entry skid buffer.
//               Out-of-range selections produce an all-zero operand and
//               raise a sticky sel_err flag.
// Ports       : clk, rst           - clock, asynchronous active-high reset
//               in_data/sel        - channels (k at [k*WIDTH +: WIDTH]), index
//               in_valid/in_ready  - upstream handshake
//               out_data/out_valid - registered operand, downstream valid
//               out_ready          - downstream accepts the beat
//               clr_err/sel_err    - clear / sticky out-of-range flag
//               out_count          - wrapping count of output transfers
// Revision    : 1.0 - initial release
// ============================================================================
module pe_operand_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    clr_err,
    output logic                    sel_err,
    output logic [15:0]             out_count
);

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_HALF  = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_sel_err;
    logic [15:0]      r_out_count;

    logic [WIDTH-1:0] w_chan [NUM_IN];
    logic [WIDTH-1:0] w_new;
    logic             w_sel_ok;
    logic             w_in_xfer;
    logic             w_out_xfer;

    generate
        for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
            assign w_chan[k] = in_data[k*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_sel_ok = (32'(sel) < 32'(NUM_IN));

    // Scan rather than index so an out-of-range sel simply falls through
    // to the all-zero default.
    always_comb begin
        w_new = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (32'(sel) == 32'(k)) begin
                w_new = w_chan[k];
            end
        end
    end

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    // in_ready and out_valid are registered alongside the state, so
    // out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_sel_err   <= 1'b0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    // Also covers the first edge after reset, where
                    // in_ready is still low and nothing is accepted.
                    r_in_ready <= 1'b1;
                    if (w_in_xfer) begin
                        r_main      <= w_new;
                        r_out_valid <= 1'b1;
                        r_state     <= c_HALF;
                    end
                end
                c_HALF: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main <= w_new;
                    end else if (w_in_xfer) begin
                        r_skid     <= w_new;
                        r_in_ready <= 1'b0;
                        r_state    <= c_FULL;
                    end else if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_EMPTY;
                    end
                end
                c_FULL: begin
                    if (w_out_xfer) begin
                        r_main     <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= c_HALF;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= c_EMPTY;
                end
            endcase

            // Set wins over a coincident clear.
            if (w_in_xfer && !w_sel_ok) begin
                r_sel_err <= 1'b1;
            end else if (clr_err) begin
                r_sel_err <= 1'b0;
            end

            if (w_out_xfer) begin
                r_out_count <= r_out_count + 16'd1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_data  = r_main;
    assign out_valid = r_out_valid;
    assign sel_err   = r_sel_err;
    assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_pe_operand_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_operand_mux
// Description : Self-checking bench for pe_operand_mux. A negedge monitor
//               pushes the expected operand for every accepted input beat
//               and pops/compares it on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_operand_mux;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    out_ready;
    logic                    clr_err;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    sel_err;
    logic [15:0]             out_count;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] sb_q[$];
    int          m_in_acc = 0;
    int          m_both   = 0;

    pe_operand_mux #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clr_err   (clr_err),
        .sel_err   (sel_err),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [95:0] chans(input logic [31:0] c0, input logic [31:0] c1,
                                          input logic [31:0] c2);
        return {c2, c1, c0};
    endfunction

    function automatic logic [31:0] expect_beat(input logic [95:0] d, input logic [1:0] s);
        if (int'(s) < NUM_IN) return d[int'(s)*32 +: 32];
        return 32'h0;
    endfunction

    // Scoreboard: pop before push so a simultaneous in/out in HALF works.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else check("sb_data", out_data, sb_q.pop_front());
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(expect_beat(in_data, sel));
                m_in_acc++;
            end
            if (in_valid && in_ready && out_valid && out_ready) m_both++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a beat until accepted; returns 1 time unit after the accepting edge.
    task automatic offer(input logic [95:0] d, input logic [1:0] s);
        bit done = 1'b0;
        in_data  = d;
        sel      = s;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            step();
        end
        in_valid = 1'b0;
        if (!done) check("offer_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!out_valid) done = 1'b1;
            else step();
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        in_data   = '0;
        sel       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_err   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_data",  out_data,       32'd0);
        check("rst_sel_err",   32'(sel_err),   32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        #1 rst = 1'b0;
        check("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rel_in_ready_high", 32'(in_ready), 32'd1);
        step();

        // Single beat, sel=1
        in_data   = chans(32'h11, 32'h22, 32'h33);
        sel       = 2'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data",  out_data,       32'h22);
        step();
        check("t1_out_count", 32'(out_count), 32'd1);
        check("t1_valid_drop", 32'(out_valid), 32'd0);

        // Backpressure: A, B fill the buffer, C is held
        out_ready = 1'b0;
        offer(chans(32'hAAAA0001, 32'h0, 32'h0), 2'd0);
        offer(chans(32'hBBBB0002, 32'h0, 32'h0), 2'd0);
        check("t2_in_ready_low", 32'(in_ready), 32'd0);
        in_data  = chans(32'hCCCC0003, 32'h0, 32'h0);
        sel      = 2'd0;
        in_valid = 1'b1;
        repeat (3) step();
        check("t2_held_in_ready", 32'(in_ready), 32'd0);
        check("t2_stable_data",   out_data,      32'hAAAA0001);
        check("t2_stable_valid",  32'(out_valid), 32'd1);
        out_ready = 1'b1;
        offer(chans(32'hCCCC0003, 32'h0, 32'h0), 2'd0);
        drain();
        check("t2_out_count", 32'(out_count), 32'd4);

        // sel_err: no set without a transfer
        out_ready = 1'b1;
        sel       = 2'd3;
        in_valid  = 1'b0;
        repeat (2) step();
        check("t3_no_xfer_no_err", 32'(sel_err), 32'd0);
        out_ready = 1'b0;
        offer(chans(32'h1, 32'h2, 32'h3), 2'd2);
        offer(chans(32'h4, 32'h5, 32'h6), 2'd0);
        in_data  = chans(32'h7, 32'h8, 32'h9);
        sel      = 2'd3;
        in_valid = 1'b1;
        repeat (2) step();
        in_valid = 1'b0;
        check("t3_blocked_no_err", 32'(sel_err), 32'd0);
        drain();
        offer(chans(32'h11, 32'h22, 32'h33), 2'd3);
        check("t3_err_set",  32'(sel_err),   32'd1);
        check("t3_zero_data", out_data,      32'd0);
        repeat (3) step();
        check("t3_err_held", 32'(sel_err), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t3_err_clr", 32'(sel_err), 32'd0);
        clr_err = 1'b1;
        offer(chans(32'h11, 32'h22, 32'h33), 2'd3);
        clr_err = 1'b0;
        check("t3_set_wins", 32'(sel_err), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        drain();

        // Streaming in HALF for 100 cycles
        out_ready = 1'b0;
        offer(chans(32'h5000_0000, 32'h0, 32'h0), 2'd0);
        out_ready = 1'b1;
        base      = m_both;
        in_valid  = 1'b1;
        sel       = 2'd0;
        for (int i = 1; i <= 100; i++) begin
            in_data = chans(32'h5000_0000 + 32'(i), 32'hDEAD, 32'hBEEF);
            step();
        end
        in_valid = 1'b0;
        check("t4_throughput", 32'(m_both - base), 32'd100);
        check("t4_half", {30'd0, in_ready, out_valid}, 32'd3);
        drain();

        // Async reset while FULL
        out_ready = 1'b0;
        offer(chans(32'h6000_0001, 32'h0, 32'h0), 2'd0);
        offer(chans(32'h6000_0002, 32'h0, 32'h0), 2'd0);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_data",  out_data,       32'd0);
        check("t5_rst_ready", 32'(in_ready),  32'd0);
        check("t5_rst_count", 32'(out_count), 32'd0);
        sb_q.delete();
        m_in_acc = 0;
        #1 rst = 1'b0;
        step();
        out_ready = 1'b1;
        offer(chans(32'hBEEF0001, 32'h0, 32'h0), 2'd0);
        @(negedge clk);
        check("t5_first_out", out_data, 32'hBEEF0001);
        step();
        drain();

        // out_count wrap
        out_ready = 1'b1;
        sel       = 2'd0;
        in_valid  = 1'b1;
        for (int i = 0; i < 70000 && m_in_acc < 65535; i++) begin
            in_data = chans(32'(m_in_acc), 32'h0, 32'h0);
            step();
        end
        in_valid = 1'b0;
        drain();
        check("t6_count_ffff", 32'(out_count), 32'h0000FFFF);
        offer(chans(32'h7777, 32'h0, 32'h0), 2'd0);
        drain();
        check("t6_count_wrap", 32'(out_count), 32'h0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
